// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, data word and default RAM latency.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int unsigned RAM_LAT_DEFAULT = 2;

endpackage

// File: rtl/ram_array.sv
// Single-port word storage: asynchronous read, synchronous write.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORDS = 4096,
  localparam int unsigned AW   = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  word_t         i_wdata,
  output word_t         o_rdata
);

  word_t r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ram_responder.sv
// RAM side of the cache/RAM handshake with programmable access latency.
// Optional address checking (misaligned / out-of-range) under `RAM_ERR_CHECK_EN.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned LAT   = RAM_LAT_DEFAULT
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam int unsigned AW   = $clog2(WORDS);
  localparam logic [3:0]  LAT4 = 4'(LAT);

  ramstate_t r_state, w_state_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic  r_ren, r_wen, w_ren_n, w_wen_n;
  word_t r_addr, r_store, w_addr_n, w_store_n;

  logic  w_any, w_bad, w_valid, w_same, w_addr_err, w_we;
  word_t w_rdata;

  assign w_any = ramREN | ramWEN;

`ifdef RAM_ERR_CHECK_EN
  assign w_addr_err = w_any && ((ramaddr[1:0] != 2'b00) || ((ramaddr >> (AW + 2)) != '0));
`else
  assign w_addr_err = 1'b0;
`endif

  assign w_bad   = (ramREN & ramWEN) | w_addr_err;
  assign w_valid = (ramREN ^ ramWEN) & ~w_addr_err;
  assign w_same  = (ramREN == r_ren) && (ramWEN == r_wen) && (ramaddr == r_addr)
                 && (!ramWEN || (ramstore == r_store));

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_ren_n   = r_ren;
    w_wen_n   = r_wen;
    w_addr_n  = r_addr;
    w_store_n = r_store;
    if (r_state == BUSY) begin
      if (w_bad) begin
        w_state_n = ERROR;
      end else if (!w_any) begin
        w_state_n = FREE;
      end else if (!w_same) begin
        // Changed request restarts the full latency from this edge.
        w_ren_n   = ramREN;
        w_wen_n   = ramWEN;
        w_addr_n  = ramaddr;
        w_store_n = ramstore;
        w_cnt_n   = LAT4;
      end else if (r_cnt == 4'd1) begin
        w_state_n = ACCESS;
        w_cnt_n   = '0;
      end else begin
        w_cnt_n = r_cnt - 4'd1;
      end
    end else begin
      if (w_valid) begin
        w_ren_n   = ramREN;
        w_wen_n   = ramWEN;
        w_addr_n  = ramaddr;
        w_store_n = ramstore;
        w_state_n = (LAT4 == 4'd0) ? ACCESS : BUSY;
        w_cnt_n   = LAT4;
      end else if (w_bad) begin
        w_state_n = ERROR;
      end else begin
        w_state_n = FREE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= FREE;
      r_cnt   <= '0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_ren   <= w_ren_n;
      r_wen   <= w_wen_n;
      r_addr  <= w_addr_n;
      r_store <= w_store_n;
    end
  end

  // Reset at the edge ending ACCESS aborts the commit.
  assign w_we = (r_state == ACCESS) && r_wen && !RST;

  ram_array #(.WORDS(WORDS)) u_array (
    .clk     (CLK),
    .i_we    (w_we),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_store),
    .o_rdata (w_rdata)
  );

  assign ramload  = ((r_state == ACCESS) && r_ren) ? w_rdata : '0;
  assign ramstate = r_state;

endmodule
